fsm_seq_ctrl: RTL and testbench

- Sequencer for the 2-bit-output FSM datapath (input X, output Y[1:0], active-high reset).
- Holds the FSM in reset for a programmable time, then drives a stored LEN-bit pattern onto X one bit per clock.
- Logs Y for every applied bit and signals completion with a start/busy/done handshake.
- Sits between a host or test controller and the FSM instance; it replaces hand-written stimulus sequences.

---
 rtl/fsm_seq_ctrl.sv | 158 +++++++++++++++
 tb/tb_fsm_seq_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/fsm_seq_ctrl.sv
// Sequencer that resets a 2-bit-output FSM, then plays a stored pattern onto X and logs Y.
// Optional macro FSM_SEQ_CMP_EN adds an expected-log compare (exp_y_in, pass, err_idx).
module fsm_seq_ctrl #(
    parameter int              LEN      = 8,
    parameter int              RST_CYC  = 2,
    parameter logic [LEN-1:0]  PAT_INIT = 'h9E
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [LEN-1:0]     pattern_in,
    input  logic               start,
    input  logic [1:0]         y_in,
`ifdef FSM_SEQ_CMP_EN
    input  logic [2*LEN-1:0]   exp_y_in,
    output logic               pass,
    output logic [5:0]         err_idx,
`endif
    output logic               x_out,
    output logic               fsm_rst,
    output logic               busy,
    output logic               done,
    output logic [2*LEN-1:0]   y_log
);

    typedef enum logic [1:0] {IDLE, INIT, RUN, DONE} state_t;

    localparam int            KW    = (LEN > 1) ? $clog2(LEN) : 1;
    localparam logic [KW-1:0] KLAST = KW'(LEN - 1);
    localparam logic [3:0]    ILAST = 4'(RST_CYC - 1);

    state_t            state, state_n;
    logic [3:0]        icnt, icnt_n;
    logic [KW-1:0]     k, k_n;
    logic [LEN-1:0]    pattern;
    logic [2*LEN-1:0]  y_log_n;
    logic              x_n, frst_n, busy_n, done_n;
    logic              go;

    assign go = (state == IDLE) && start;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            icnt    <= '0;
            k       <= '0;
            pattern <= PAT_INIT;
            y_log   <= '0;
        end else begin
            state <= state_n;
            icnt  <= icnt_n;
            k     <= k_n;
            y_log <= y_log_n;
            if (state == IDLE && load)
                pattern <= pattern_in;
        end
    end

    always_comb begin
        state_n = state;
        icnt_n  = icnt;
        k_n     = k;
        y_log_n = y_log;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_n = INIT;
                    icnt_n  = '0;
                    y_log_n = '0;
                end
            end
            INIT: begin
                if (icnt == ILAST) begin
                    state_n = RUN;
                    k_n     = '0;
                end else begin
                    icnt_n = icnt + 4'd1;
                end
            end
            RUN: begin
                y_log_n[{k, 1'b0} +: 2] = y_in;
                if (k == KLAST)
                    state_n = DONE;
                else
                    k_n = k + KW'(1);
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they register in step with it
    always_comb begin
        x_n    = 1'b0;
        frst_n = 1'b0;
        busy_n = 1'b0;
        done_n = 1'b0;
        unique case (state_n)
            IDLE: ;
            INIT: begin
                frst_n = 1'b1;
                busy_n = 1'b1;
            end
            RUN: begin
                busy_n = 1'b1;
                x_n    = pattern[k_n];
            end
            DONE: done_n = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_out   <= 1'b0;
            fsm_rst <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            x_out   <= x_n;
            fsm_rst <= frst_n;
            busy    <= busy_n;
            done    <= done_n;
        end
    end

`ifdef FSM_SEQ_CMP_EN
    logic [2*LEN-1:0] exp_q;
    logic [5:0]       first_bad;
    logic             last;

    assign last = (state == RUN) && (k == KLAST);

    always_comb begin
        first_bad = 6'd63;
        for (int i = LEN - 1; i >= 0; i--) begin
            if (y_log_n[2*i +: 2] != exp_q[2*i +: 2])
                first_bad = 6'(i);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            exp_q   <= '0;
            pass    <= 1'b0;
            err_idx <= 6'd63;
        end else if (go) begin
            exp_q   <= exp_y_in;
            pass    <= 1'b0;
            err_idx <= 6'd63;
        end else if (last) begin
            pass    <= (y_log_n == exp_q);
            err_idx <= first_bad;
        end
    end
`endif

endmodule

// File: tb/tb_fsm_seq_ctrl.sv
// Directed testbench for fsm_seq_ctrl (LEN=8, RST_CYC=2).
// Compare checks run only when FSM_SEQ_CMP_EN is defined.
module tb_fsm_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        load = 1'b0;
    logic [7:0]  pattern_in = 8'h00;
    logic        start = 1'b0;
    logic [1:0]  y_in = 2'b00;
    logic        x_out, fsm_rst, busy, done;
    logic [15:0] y_log;
`ifdef FSM_SEQ_CMP_EN
    logic [15:0] exp_y_in = 16'h0000;
    logic        pass;
    logic [5:0]  err_idx;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fsm_seq_ctrl #(.LEN(8), .RST_CYC(2), .PAT_INIT(8'h9E)) dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .pattern_in (pattern_in),
        .start      (start),
        .y_in       (y_in),
`ifdef FSM_SEQ_CMP_EN
        .exp_y_in   (exp_y_in),
        .pass       (pass),
        .err_idx    (err_idx),
`endif
        .x_out      (x_out),
        .fsm_rst    (fsm_rst),
        .busy       (busy),
        .done       (done),
        .y_log      (y_log)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // t counts cycles after the start edge: t=0,1 INIT, t=2..9 RUN, t=10 DONE
    task automatic do_run(input string nm, input logic pre_load,
                          input logic [7:0] pre_pat, input logic [7:0] exp_x,
                          input logic [15:0] ydrv, input int inj_t,
                          input logic inj_load, input logic inj_start,
                          input logic [7:0] inj_pat);
        int         frst_cnt = 0;
        int         done_cnt = 0;
        int         done_t = -1;
        logic [7:0] xs = 8'h00;
        load       = pre_load;
        pattern_in = pre_pat;
        start      = 1'b1;
        tick();
        load  = 1'b0;
        start = 1'b0;
        for (int t = 0; t <= 12; t++) begin
            if (fsm_rst === 1'b1) frst_cnt++;
            if (done === 1'b1) begin
                done_cnt++;
                done_t = t;
            end
            if (t >= 2 && t <= 9) xs[t-2] = x_out;
            if (t == 0 || t == 9 || t == 10 || t == 12) begin
                checks++;
                if (busy !== (t <= 9)) begin
                    errors++;
                    $display("FAIL %s busy t=%0d got=%b exp=%b", nm, t, busy, (t <= 9));
                end
            end
            y_in = (t >= 2 && t <= 9) ? ydrv[2*(t-2) +: 2] : 2'b00;
            if (t == inj_t) begin
                load       = inj_load;
                start      = inj_start;
                pattern_in = inj_pat;
            end else begin
                load  = 1'b0;
                start = 1'b0;
            end
            tick();
        end
        y_in = 2'b00;
        checks++;
        if (frst_cnt !== 2) begin
            errors++;
            $display("FAIL %s fsm_rst_cycles got=%0d exp=2", nm, frst_cnt);
        end
        checks++;
        if (xs !== exp_x) begin
            errors++;
            $display("FAIL %s x_seq got=%h exp=%h", nm, xs, exp_x);
        end
        checks++;
        if (done_cnt !== 1 || done_t !== 10) begin
            errors++;
            $display("FAIL %s done got=%0d pulses at t=%0d exp=1 at t=10", nm, done_cnt, done_t);
        end
        checks++;
        if (y_log !== ydrv) begin
            errors++;
            $display("FAIL %s y_log got=%h exp=%h", nm, y_log, ydrv);
        end
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({x_out, fsm_rst, busy, done} !== 4'b0100 || y_log !== 16'h0) begin
            errors++;
            $display("FAIL reset_vals got=%b/%h exp=0100/0000", {x_out, fsm_rst, busy, done}, y_log);
        end
        tick();
        reset = 1'b1;
        tick();
        checks++;
        if (fsm_rst !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset got rst=%b busy=%b exp 0 0", fsm_rst, busy);
        end
    endtask

    task automatic test_default();
        do_run("default", 1'b0, 8'h00, 8'h9E, 16'hAAAA, -1, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_capture();
        do_run("capture", 1'b0, 8'h00, 8'h9E, 16'hAA6A, -1, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_load_start();
        do_run("ld_start", 1'b1, 8'h0F, 8'h0F, 16'h1B1B, 3, 1'b1, 1'b0, 8'hFF);
        do_run("ld_busy", 1'b0, 8'h00, 8'h0F, 16'hE4E4, -1, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_start_busy();
        do_run("start_busy", 1'b0, 8'h00, 8'h0F, 16'h5A5A, 4, 1'b0, 1'b1, 8'h00);
    endtask

    task automatic test_reset_mid();
        int dcnt = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        y_in  = 2'b11;
        for (int t = 0; t < 6; t++) tick();
        checks++;
        if (y_log !== 16'h00FF || busy !== 1'b1) begin
            errors++;
            $display("FAIL pre_abort got ylog=%h busy=%b exp 00ff 1", y_log, busy);
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({x_out, fsm_rst, busy, done} !== 4'b0100 || y_log !== 16'h0) begin
            errors++;
            $display("FAIL abort_vals got=%b/%h exp=0100/0000", {x_out, fsm_rst, busy, done}, y_log);
        end
        y_in = 2'b00;
        tick();
        tick();
        reset = 1'b1;
        tick();
        checks++;
        if (fsm_rst !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL post_abort_idle got rst=%b busy=%b exp 0 0", fsm_rst, busy);
        end
        for (int t = 0; t < 12; t++) begin
            if (done === 1'b1 || busy === 1'b1) dcnt++;
            tick();
        end
        checks++;
        if (dcnt !== 0) begin
            errors++;
            $display("FAIL post_abort_activity got=%0d exp=0", dcnt);
        end
    endtask

`ifdef FSM_SEQ_CMP_EN
    task automatic test_compare();
        exp_y_in = 16'h1234;
        do_run("cmp_ok", 1'b0, 8'h00, 8'h9E, 16'h1234, -1, 1'b0, 1'b0, 8'h00);
        checks++;
        if (pass !== 1'b1 || err_idx !== 6'd63) begin
            errors++;
            $display("FAIL cmp_ok got pass=%b idx=%0d exp 1 63", pass, err_idx);
        end
        exp_y_in = 16'h1234 ^ 16'h0C00;
        do_run("cmp_bad", 1'b0, 8'h00, 8'h9E, 16'h1234, -1, 1'b0, 1'b0, 8'h00);
        checks++;
        if (pass !== 1'b0 || err_idx !== 6'd5) begin
            errors++;
            $display("FAIL cmp_bad got pass=%b idx=%0d exp 0 5", pass, err_idx);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_default();
        test_capture();
        test_load_start();
        test_start_busy();
        test_reset_mid();
`ifdef FSM_SEQ_CMP_EN
        test_compare();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
